// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory and single ALU, with a mem_ready stall watchdog.
module mips_multicycle_controller #(
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opCode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcWrite,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic [1:0]         regDst,
    output logic [1:0]         regSrc,
    output logic               regWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         pcSrc,
    output logic               illegal,
    output logic               memFault,
    output logic [3:0]         state
);
    // Encoding is fixed so the debug state port is stable across builds.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMM_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_JR       = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0,  OP_J    = 6'd2,  OP_JAL = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4,  OP_BNE  = 6'd5,  OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10, OP_LW   = 6'd35, OP_SW  = 6'd43;
    localparam logic [5:0] FN_JR    = 6'd8,  FN_ADD  = 6'd32, FN_SUB = 6'd34;
    localparam logic [5:0] FN_SLT   = 6'd42;

    state_t          state_reg, state_next;
    logic [TO_W-1:0] stall_reg, stall_next;
    logic [1:0]      alu_sel;
    logic            waiting;
    logic            timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            stall_reg <= '0;
        end else begin
            state_reg <= state_next;
            stall_reg <= stall_next;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && (stall_reg == TO_W'(MEM_TIMEOUT)) && !mem_ready;
    // Counting only while parked in a wait state; any exit or a fault restarts it.
    assign stall_next = (waiting && !mem_ready && !timeout) ? stall_reg + 1'b1 : '0;

    always_comb begin
        state_next = state_reg;
        pcWrite    = 1'b0;
        iorD       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regDst     = 2'd0;
        regSrc     = 2'd0;
        regWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        alu_sel    = 2'd0;
        pcSrc      = 2'd0;
        illegal    = 1'b0;
        memFault   = 1'b0;
        waiting    = 1'b0;
        case (state_reg)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                memRead = 1'b1;
                ALUSrcB = 2'd1;
                waiting = 1'b1;
                if (mem_ready) begin
                    irWrite    = 1'b1;
                    pcWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    memFault = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'd3;
                case (opCode)
                    OP_RTYPE: begin
                        if (func == FN_ADD || func == FN_SUB || func == FN_SLT)
                            state_next = S_RTYPE_EX;
                        else if (func == FN_JR)
                            state_next = S_JR;
                        else begin
                            illegal    = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW:     state_next = S_MEMADR;
                    OP_ADDI, OP_SLTI: state_next = S_IMM_EX;
                    OP_BEQ, OP_BNE:   state_next = S_BRANCH;
                    OP_J:             state_next = S_JUMP;
                    OP_JAL:           state_next = S_JAL;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_RTYPE_EX: begin
                ALUSrcA    = 1'b1;
                alu_sel    = (func == FN_SUB) ? 2'd1 : (func == FN_SLT) ? 2'd2 : 2'd0;
                state_next = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                regDst     = 2'd1;
                regSrc     = 2'd2;
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_IMM_EX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                alu_sel    = (opCode == OP_SLTI) ? 2'd2 : 2'd0;
                state_next = S_IMM_WB;
            end
            S_IMM_WB: begin
                regSrc     = 2'd2;
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                state_next = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iorD    = 1'b1;
                memRead = 1'b1;
                waiting = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
                else if (timeout) begin
                    memFault   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEMWB: begin
                regSrc     = 2'd1;
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
                waiting  = 1'b1;
                if (mem_ready) state_next = S_FETCH;
                else if (timeout) begin
                    memFault   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                alu_sel    = 2'd1;
                pcSrc      = 2'd1;
                pcWrite    = (opCode == OP_BNE) ? ~zero : zero;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pcSrc      = 2'd2;
                pcWrite    = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                pcSrc      = 2'd2;
                pcWrite    = 1'b1;
                regDst     = 2'd2;
                regWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_JR: begin
                pcSrc      = 2'd3;
                pcWrite    = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign ALUOp = ALUOP_W'(alu_sel);
    assign state = state_reg;
endmodule
